fetch_decode_buffer: RTL and testbench

- Small instruction FIFO between the fetch unit and decode.
- Decouples decode stalls from the fetch ROM's 1-cycle read latency.
- Accepts {instruction, PC} pairs from fetch and presents them in order to decode with a valid/ready handshake.
- Supports a single-cycle flush for branch/JAL/JALR redirects, which discards wrong-path instructions.

---
 rtl/fetch_decode_buffer_pkg.sv | 34 +++
 rtl/fetch_buf_storage.sv | 29 ++
 rtl/fetch_decode_buffer.sv | 154 +++++++++++++++
 tb/tb_fetch_decode_buffer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fetch_decode_buffer_pkg.sv
// Shared constants and helpers for the fetch-to-decode instruction buffer.
// Used by fetch_decode_buffer and fetch_buf_storage; FETCH_BUF_STATS_EN uses sat_inc32.
package fetch_decode_buffer_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_e;

    // Ceiling log2; returns 1 for values of 1 or less so widths never collapse to zero.
    function automatic int fdb_log2(input int value);
        int result;
        result = 0;
        while ((32'sd1 <<< result) < value) begin
            result = result + 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        if (value == 32'hFFFF_FFFF) begin
            return value;
        end else begin
            return value + 32'd1;
        end
    endfunction

endpackage

// File: rtl/fetch_buf_storage.sv
// Register-array entry store for the fetch buffer: one write port, one
// asynchronous read port. Contents carry no reset.
module fetch_buf_storage
    import fetch_decode_buffer_pkg::*;
#(
    parameter int WIDTH = 52,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clock,
    input  logic             wr_en_i,
    input  logic [PTR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [PTR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Entry write.
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fetch_decode_buffer.sv
// In-order {instruction, PC} FIFO between fetch and decode with single-cycle flush.
// Optional FETCH_BUF_STATS_EN adds internal stall/empty/flush counters.
module fetch_decode_buffer
    import fetch_decode_buffer_pkg::*;
#(
    parameter int          DATA_WIDTH   = 32,
    parameter int          ADDRESS_BITS = 20,
    parameter int          DEPTH        = 4,
    parameter logic [31:0] NOP_VALUE    = NOP_INST,
    localparam int         PTR_W        = fdb_log2(DEPTH),
    localparam int         CNT_W        = PTR_W + 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_instruction,
    input  logic [ADDRESS_BITS-1:0] in_PC,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [DATA_WIDTH-1:0]   out_instruction,
    output logic [ADDRESS_BITS-1:0] out_PC,
    input  logic                    out_ready,
    output logic [CNT_W-1:0]        count,
    input  logic                    report
);

    localparam int ENTRY_W = DATA_WIDTH + ADDRESS_BITS;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    occ_e               occ_s;
    logic               in_ready_s;
    logic               out_valid_s;
    logic               push_s;
    logic               pop_s;
    logic [ENTRY_W-1:0] head_s;

    fetch_buf_storage #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_storage (
        .clock     (clock),
        .wr_en_i   (push_s),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i ({in_instruction, in_PC}),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (head_s)
    );

    // Occupancy, handshakes and next pointer/count; flush outranks push and pop.
    always_comb begin
        occ_s    = OCC_PARTIAL;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (count_q == {CNT_W{1'b0}}) begin
            occ_s = OCC_EMPTY;
        end else if (count_q == CNT_W'(DEPTH)) begin
            occ_s = OCC_FULL;
        end else begin
            occ_s = OCC_PARTIAL;
        end
        in_ready_s  = (occ_s != OCC_FULL);
        out_valid_s = (occ_s != OCC_EMPTY);
        push_s      = in_valid & in_ready_s & ~flush;
        pop_s       = out_valid_s & out_ready & ~flush;
        if (flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign in_ready        = in_ready_s;
    assign out_valid       = out_valid_s;
    assign count           = count_q;
    assign out_instruction = out_valid_s ? head_s[ENTRY_W-1:ADDRESS_BITS] : NOP_VALUE[DATA_WIDTH-1:0];
    assign out_PC          = out_valid_s ? head_s[ADDRESS_BITS-1:0] : {ADDRESS_BITS{1'b0}};

`ifdef FETCH_BUF_STATS_EN
    logic [31:0] full_stall_cycles_q;
    logic [31:0] empty_cycles_q;
    logic [31:0] flush_count_q;

    // Saturating activity counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            full_stall_cycles_q <= 32'd0;
            empty_cycles_q      <= 32'd0;
            flush_count_q       <= 32'd0;
        end else begin
            if (in_valid & ~in_ready_s) begin
                full_stall_cycles_q <= sat_inc32(full_stall_cycles_q);
            end
            if (~out_valid_s) begin
                empty_cycles_q <= sat_inc32(empty_cycles_q);
            end
            if (flush) begin
                flush_count_q <= sat_inc32(flush_count_q);
            end
        end
    end
`endif

`ifndef SYNTHESIS
    // Simulation-only status print.
    always_ff @(posedge clock) begin
        if (report) begin
`ifdef FETCH_BUF_STATS_EN
            $display("fetch_decode_buffer: count=%0d rd=%0d wr=%0d pc=%h inst=%h in_v=%b in_r=%b out_v=%b out_r=%b stall=%0d empty=%0d flushes=%0d",
                     count_q, rd_ptr_q, wr_ptr_q, out_PC, out_instruction, in_valid, in_ready_s,
                     out_valid_s, out_ready, full_stall_cycles_q, empty_cycles_q, flush_count_q);
`else
            $display("fetch_decode_buffer: count=%0d rd=%0d wr=%0d pc=%h inst=%h in_v=%b in_r=%b out_v=%b out_r=%b",
                     count_q, rd_ptr_q, wr_ptr_q, out_PC, out_instruction, in_valid, in_ready_s,
                     out_valid_s, out_ready);
`endif
        end
    end
`endif

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Directed self-checking bench for fetch_decode_buffer (default parameters).
module tb_fetch_decode_buffer;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instruction;
    logic [19:0] in_PC;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_instruction;
    logic [19:0] out_PC;
    logic        out_ready;
    logic [2:0]  count;
    logic        report;

    int checks;
    int errors;

    fetch_decode_buffer dut (
        .clock           (clock),
        .reset           (reset),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_instruction  (in_instruction),
        .in_PC           (in_PC),
        .in_ready        (in_ready),
        .out_valid       (out_valid),
        .out_instruction (out_instruction),
        .out_PC          (out_PC),
        .out_ready       (out_ready),
        .count           (count),
        .report          (report)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_one(input logic [19:0] pc, input logic [31:0] inst);
        in_valid       = 1'b1;
        in_PC          = pc;
        in_instruction = inst;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instruction = 32'd0;
        in_PC = 20'd0; out_ready = 1'b0; report = 1'b0;
        step(); step();
        reset = 1'b0;
        step();

        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_inst", 64'(out_instruction), 64'h13);
        chk("rst_out_pc", 64'(out_PC), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_count", 64'(count), 64'd0);

        // Fill to FULL, then a dropped fifth push.
        for (int i = 0; i < 4; i++) begin
            push_one(20'(i * 4), 32'hA000_0000 + 32'(i));
        end
        chk("full_count", 64'(count), 64'd4);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        push_one(20'h00010, 32'hA000_0004);
        chk("full_drop_count", 64'(count), 64'd4);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc", 64'(out_PC), 64'(i * 4));
            chk("drain_inst", 64'(out_instruction), 64'(32'hA000_0000 + 32'(i)));
            step();
        end
        out_ready = 1'b0;
        chk("drain_count", 64'(count), 64'd0);
        chk("drain_out_valid", 64'(out_valid), 64'd0);

        // Streaming across pointer wrap.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_PC          = 20'h00040 + 20'(i * 4);
            in_instruction = 32'hB000_0000 + 32'(i);
            step();
            chk("stream_count", 64'(count), 64'd1);
            chk("stream_pc", 64'(out_PC), 64'(20'h00040 + 20'(i * 4)));
            chk("stream_inst", 64'(out_instruction), 64'(32'hB000_0000 + 32'(i)));
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        chk("stream_end_count", 64'(count), 64'd0);

        // Flush with simultaneous push and pop.
        for (int i = 0; i < 3; i++) begin
            push_one(20'h00080 + 20'(i * 4), 32'hC000_0000 + 32'(i));
        end
        chk("pre_flush_count", 64'(count), 64'd3);
        flush = 1'b1; in_valid = 1'b1; in_PC = 20'h00100; in_instruction = 32'hC000_0100;
        out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_out_inst", 64'(out_instruction), 64'h13);
        push_one(20'h00200, 32'hC000_0200);
        chk("post_flush_pc", 64'(out_PC), 64'h200);
        chk("post_flush_count", 64'(count), 64'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("post_flush_empty", 64'(count), 64'd0);

        // FULL with pop and push together: only the pop happens.
        for (int i = 0; i < 4; i++) begin
            push_one(20'h00300 + 20'(i * 4), 32'hD000_0000 + 32'(i));
        end
        out_ready = 1'b1; in_valid = 1'b1; in_PC = 20'h00400; in_instruction = 32'hD000_0400;
        step();
        in_valid = 1'b0;
        chk("full_pop_count", 64'(count), 64'd3);
        for (int i = 1; i < 4; i++) begin
            chk("full_pop_order", 64'(out_PC), 64'(20'h00300 + 20'(i * 4)));
            step();
        end
        out_ready = 1'b0;
        chk("full_pop_empty", 64'(count), 64'd0);

        // Reset mid-operation.
        push_one(20'h00500, 32'hE000_0000);
        push_one(20'h00504, 32'hE000_0001);
        chk("pre_reset_count", 64'(count), 64'd2);
        report = 1'b1;
        reset  = 1'b1;
        step();
        reset  = 1'b0;
        report = 1'b0;
        chk("mid_reset_count", 64'(count), 64'd0);
        chk("mid_reset_valid", 64'(out_valid), 64'd0);
        chk("mid_reset_pc", 64'(out_PC), 64'd0);

`ifdef FETCH_BUF_STATS_EN
        chk("stats_flush_rst", 64'(dut.flush_count_q), 64'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("stats_flush_1", 64'(dut.flush_count_q), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("stats_flush_2", 64'(dut.flush_count_q), 64'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
